// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the TX arbiter: FSM states, grant source encoding
// and the WAIT_BUSY watchdog limit (used only when TX_ARBITER_WATCHDOG_EN is defined).
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CFG  = 2'd1,
    SRC_DS   = 2'd2,
    SRC_LOC  = 2'd3
  } arb_src_e;

  localparam logic [2:0] WD_LIMIT = 3'd7;

endpackage

// File: rtl/tx_arb_rr2.sv
// Two-way round-robin between the downstream (ds) and local (loc) requesters.
// The 1-bit pointer favours whichever of the two was not granted last.
module tx_arb_rr2
  import tx_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_ds_i,
  input  logic req_loc_i,
  input  logic adv_i,
  output logic gnt_ds_o,
  output logic gnt_loc_o
);

  // ptr_q = 0 favours ds, 1 favours loc
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_ds_o  = 1'b0;
    gnt_loc_o = 1'b0;
    if (req_ds_i && (!req_loc_i || !ptr_q)) begin
      gnt_ds_o = 1'b1;
    end else if (req_loc_i) begin
      gnt_loc_o = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (gnt_ds_o || gnt_loc_o)) begin
      ptr_d = gnt_ds_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates cfg / ds / loc packets onto a single TX UART (cfg has strict priority).
// Optional WAIT_BUSY watchdog is enabled by defining TX_ARBITER_WATCHDOG_EN.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             txclk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  input  logic [WIDTH-2:0] cfg_data,
  input  logic             ds_valid,
  input  logic [WIDTH-2:0] ds_data,
  input  logic             loc_valid,
  input  logic [WIDTH-2:0] loc_data,
  input  logic             tx_enable,
  input  logic             tx_busy,
  output logic             cfg_ack,
  output logic             ds_ack,
  output logic             loc_ack,
  output logic [WIDTH-2:0] tx_data,
  output logic             ld_tx_data,
  output logic             arb_idle,
  output logic             tx_stall_err
);

  arb_state_e       state_q, state_d;
  arb_src_e         src_q, src_d;
  logic [WIDTH-2:0] tx_data_q, tx_data_d;
  logic             can_grant, rr_adv, gnt_ds, gnt_loc;

  assign can_grant = tx_enable && !tx_busy && (cfg_valid || ds_valid || loc_valid);

  tx_arb_rr2 u_rr2 (
    .clk_i     (txclk),
    .rst_ni    (reset_n),
    .req_ds_i  (ds_valid),
    .req_loc_i (loc_valid),
    .adv_i     (rr_adv),
    .gnt_ds_o  (gnt_ds),
    .gnt_loc_o (gnt_loc)
  );

`ifdef TX_ARBITER_WATCHDOG_EN
  logic [2:0] wd_q, wd_d;
  logic       err_q, err_d, wd_expire;

  assign wd_expire = (state_q == ST_WAIT_BUSY) && !tx_busy && (wd_q == WD_LIMIT - 3'd1);

  always_comb begin
    wd_d  = 3'd0;
    err_d = err_q | wd_expire;
    if (state_q == ST_WAIT_BUSY && !tx_busy && !wd_expire) wd_d = wd_q + 3'd1;
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= 3'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign tx_stall_err = err_q;
`else
  assign tx_stall_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    tx_data_d = tx_data_q;
    rr_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          state_d = ST_LOAD;
          if (cfg_valid) begin
            src_d     = SRC_CFG;
            tx_data_d = cfg_data;
          end else begin
            rr_adv = 1'b1;
            if (gnt_ds) begin
              src_d     = SRC_DS;
              tx_data_d = ds_data;
            end else if (gnt_loc) begin
              src_d     = SRC_LOC;
              tx_data_d = loc_data;
            end
          end
        end
      end
      ST_LOAD: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy) state_d = ST_WAIT_DONE;
`ifdef TX_ARBITER_WATCHDOG_EN
        else if (wd_expire) state_d = ST_IDLE;
`endif
      end
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_NONE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Strobes decode the registered state only, so they clear with reset immediately
  assign ld_tx_data = (state_q == ST_LOAD);
  assign cfg_ack    = ld_tx_data && (src_q == SRC_CFG);
  assign ds_ack     = ld_tx_data && (src_q == SRC_DS);
  assign loc_ack    = ld_tx_data && (src_q == SRC_LOC);
  assign arb_idle   = (state_q == ST_IDLE);
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter; watchdog expectations follow TX_ARBITER_WATCHDOG_EN.
module tb_tx_arbiter;
  localparam int WIDTH = 64;

  logic             txclk = 1'b0;
  logic             reset_n;
  logic             cfg_valid, ds_valid, loc_valid, tx_enable, tx_busy;
  logic [WIDTH-2:0] cfg_data, ds_data, loc_data;
  logic             cfg_ack, ds_ack, loc_ack, ld_tx_data, arb_idle, tx_stall_err;
  logic [WIDTH-2:0] tx_data;

  int total = 0;
  int bad   = 0;

  always #5 txclk = ~txclk;

  tx_arbiter #(.WIDTH(WIDTH)) dut (
    .txclk        (txclk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .ds_valid     (ds_valid),
    .ds_data      (ds_data),
    .loc_valid    (loc_valid),
    .loc_data     (loc_data),
    .tx_enable    (tx_enable),
    .tx_busy      (tx_busy),
    .cfg_ack      (cfg_ack),
    .ds_ack       (ds_ack),
    .loc_ack      (loc_ack),
    .tx_data      (tx_data),
    .ld_tx_data   (ld_tx_data),
    .arb_idle     (arb_idle),
    .tx_stall_err (tx_stall_err)
  );

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b0; ds_valid = 1'b0; loc_valid = 1'b0;
    cfg_data  = '0;   ds_data  = '0;   loc_data  = '0;
    tx_enable = 1'b1; tx_busy  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Runs the UART busy handshake from LOAD back to IDLE.
  task automatic xfer();
    tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic wait_ld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ld_tx_data) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b1; cfg_data = 63'h7abc;
    ds_valid  = 1'b0; loc_valid = 1'b0; ds_data = '0; loc_data = '0;
    tx_enable = 1'b1; tx_busy = 1'b0;
    tick();
    tick();
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", arb_idle); end
    total++; if (ld_tx_data !== 1'b0) begin bad++; $display("FAIL rst_ld: got %b want 0", ld_tx_data); end
    total++; if ({cfg_ack, ds_ack, loc_ack} !== 3'b000) begin bad++; $display("FAIL rst_acks: got %b want 000", {cfg_ack, ds_ack, loc_ack}); end
    total++; if (tx_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", tx_data); end
    total++; if (tx_stall_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", tx_stall_err); end
    cfg_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_single_loc();
    loc_valid = 1'b1; loc_data = 63'h1234;
    total++; if (ld_tx_data !== 1'b0) begin bad++; $display("FAIL loc_ld_early: got %b want 0", ld_tx_data); end
    tick();
    // LOAD: the strobe is captured by the UART at the next (second) edge
    total++; if (ld_tx_data !== 1'b1) begin bad++; $display("FAIL loc_ld: got %b want 1", ld_tx_data); end
    total++; if ({cfg_ack, ds_ack, loc_ack} !== 3'b001) begin bad++; $display("FAIL loc_ack: got %b want 001", {cfg_ack, ds_ack, loc_ack}); end
    total++; if (tx_data !== 63'h1234) begin bad++; $display("FAIL loc_data: got %h want 1234", tx_data); end
    loc_valid = 1'b0;
    tx_busy   = 1'b1;
    tick();
    total++; if ({ld_tx_data, cfg_ack, ds_ack, loc_ack} !== 4'b0000) begin bad++; $display("FAIL loc_pulse_len: got %b want 0000", {ld_tx_data, cfg_ack, ds_ack, loc_ack}); end
    repeat (9) tick();
    total++; if (arb_idle !== 1'b0) begin bad++; $display("FAIL loc_busy_idle: got %b want 0", arb_idle); end
    tx_busy = 1'b0;
    tick();
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL loc_done_idle: got %b want 1", arb_idle); end
    total++; if (tx_data !== 63'h1234) begin bad++; $display("FAIL loc_data_hold: got %h want 1234", tx_data); end
  endtask

  task automatic test_priority();
    logic [2:0]       exp_ack [4];
    logic [WIDTH-2:0] exp_dat [4];
    bit ok;
    exp_ack = '{3'b100, 3'b010, 3'b001, 3'b010};
    exp_dat = '{63'h11, 63'h22, 63'h33, 63'h22};
    do_reset();
    cfg_valid = 1'b1; cfg_data = 63'h11;
    ds_valid  = 1'b1; ds_data  = 63'h22;
    loc_valid = 1'b1; loc_data = 63'h33;
    for (int g = 0; g < 4; g++) begin
      wait_ld(ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL prio_timeout: grant %0d got none want ld", g);
      end else begin
        if ({cfg_ack, ds_ack, loc_ack} !== exp_ack[g]) begin
          bad++; $display("FAIL prio_order: grant %0d got %b want %b", g, {cfg_ack, ds_ack, loc_ack}, exp_ack[g]);
        end
        total++;
        if (tx_data !== exp_dat[g]) begin
          bad++; $display("FAIL prio_data: grant %0d got %h want %h", g, tx_data, exp_dat[g]);
        end
      end
      if (cfg_ack) cfg_valid = 1'b0;
      xfer();
    end
    ds_valid = 1'b0; loc_valid = 1'b0;
  endtask

  task automatic test_enable();
    int cnt;
    cnt = 0;
    tx_enable = 1'b0;
    ds_valid  = 1'b1; ds_data = 63'h55;
    repeat (20) begin
      tick();
      if (ld_tx_data) cnt++;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL en_block: got %0d loads want 0", cnt); end
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL en_idle: got %b want 1", arb_idle); end
    tx_enable = 1'b1;
    tick();
    total++; if ({ld_tx_data, ds_ack} !== 2'b11) begin bad++; $display("FAIL en_grant: got %b want 11", {ld_tx_data, ds_ack}); end
    total++; if (tx_data !== 63'h55) begin bad++; $display("FAIL en_data: got %h want 55", tx_data); end
    tx_enable = 1'b0;
    ds_valid  = 1'b0;
    xfer();
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL en_complete: got %b want 1", arb_idle); end
    tx_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    ds_valid = 1'b1; ds_data = 63'h77;
    tick();
    total++; if (ds_ack !== 1'b1) begin bad++; $display("FAIL mid_grant: got %b want 1", ds_ack); end
    ds_valid = 1'b0;
    tx_busy  = 1'b1;
    tick();
    tick();
    total++; if (arb_idle !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", arb_idle); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL mid_async_idle: got %b want 1", arb_idle); end
    total++; if (tx_data !== '0) begin bad++; $display("FAIL mid_async_data: got %h want 0", tx_data); end
    total++; if ({ld_tx_data, cfg_ack, ds_ack, loc_ack} !== 4'b0000) begin bad++; $display("FAIL mid_async_strobes: got %b want 0000", {ld_tx_data, cfg_ack, ds_ack, loc_ack}); end
    tx_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (4) begin
      tick();
      if (ld_tx_data || cfg_ack || ds_ack || loc_ack) cnt++;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL mid_spurious: got %0d strobes want 0", cnt); end
    // last grant before reset was ds, so only a reset pointer lets ds win here
    ds_valid = 1'b1; loc_valid = 1'b1; ds_data = 63'h88; loc_data = 63'h99;
    tick();
    total++; if ({ld_tx_data, ds_ack, loc_ack} !== 3'b110) begin bad++; $display("FAIL mid_first_grant: got %b want 110", {ld_tx_data, ds_ack, loc_ack}); end
    ds_valid = 1'b0; loc_valid = 1'b0;
    xfer();
  endtask

  task automatic test_watchdog();
    loc_valid = 1'b1; loc_data = 63'h4242;
    tick();
    total++; if ({ld_tx_data, loc_ack} !== 2'b11) begin bad++; $display("FAIL wd_grant: got %b want 11", {ld_tx_data, loc_ack}); end
    loc_valid = 1'b0;
    repeat (7) tick();
    total++; if ({arb_idle, tx_stall_err} !== 2'b00) begin bad++; $display("FAIL wd_early: got %b want 00", {arb_idle, tx_stall_err}); end
    tick();
`ifdef TX_ARBITER_WATCHDOG_EN
    total++; if ({arb_idle, tx_stall_err} !== 2'b11) begin bad++; $display("FAIL wd_expire: got %b want 11", {arb_idle, tx_stall_err}); end
    repeat (3) tick();
    total++; if (tx_stall_err !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", tx_stall_err); end
`else
    total++; if ({arb_idle, tx_stall_err} !== 2'b00) begin bad++; $display("FAIL wd_disabled: got %b want 00", {arb_idle, tx_stall_err}); end
`endif
    do_reset();
    total++; if ({arb_idle, tx_stall_err} !== 2'b10) begin bad++; $display("FAIL wd_clear: got %b want 10", {arb_idle, tx_stall_err}); end
  endtask

  initial begin
    test_reset();
    test_single_loc();
    test_priority();
    test_enable();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
